vc_input_port: RTL and testbench
================================

VC_INPUT_PORT -- requirements
Module: vc_input_port

Interface
REQ-001 Parameter DATA_WIDTH, default 64, packet width; bit 63 = VC, bit 62 = direction, bits 55:48 = hop count, rest payload.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 polarity  input  1  router polarity for the current cycle (0 even, 1 odd).
REQ-005 si  input  1  upstream send strobe (from NIC net_so or neighbour router).
REQ-006 ri  output  1  ready to upstream.
REQ-007 di  input  DATA_WIDTH  upstream packet data.
REQ-008 req_ring  output  1  buffered packet for internal forwarding continues around the ring.
REQ-009 req_pe  output  1  buffered packet for internal forwarding is for the local PE.
REQ-010 gnt  input  1  downstream arbiter accepts the presented packet this cycle.
REQ-011 dout  output  DATA_WIDTH  presented packet, hop field already updated.
REQ-012 proto_err  output  1  sticky flag: upstream sent a packet on the wrong VC.

Function
REQ-013 Two single-entry buffers, buf[0] (even VC) and buf[1] (odd VC), each with a full bit.
REQ-014 External VC this cycle = ~polarity; internal VC = polarity.
REQ-015 ri = ~full[~polarity], combinational.
REQ-016 Write: si & ri & di[63] == ~polarity at clock edge -> buf[~polarity] <= di, full[~polarity] <= 1.
REQ-017 si & ri & di[63] == polarity: packet dropped, no buffer change, proto_err <= 1 (sticky until reset).
REQ-018 si while ri = 0: ignored, no state change, no error.
REQ-019 Presentation: req_ring = full[polarity] & (hop != 0); req_pe = full[polarity] & (hop == 0), where hop = buf[polarity][55:48].
REQ-020 dout = buf[polarity] with bits 55:48 replaced by hop-1 when hop != 0, unchanged when hop == 0; all other bits pass through.
REQ-021 dout = 0 when full[polarity] = 0.
REQ-022 gnt & (req_ring | req_pe) at edge -> full[polarity] <= 0; gnt with no request is ignored.
REQ-023 Latency: a packet written at edge N is presentable at edge N+1 only if polarity has toggled, so minimum input-to-request latency is 1 cycle.
REQ-024 Write and grant target different VCs in the same cycle, so both take effect together.
REQ-025 Hop decrement never wraps: hop 0 goes to PE and is never decremented.
REQ-026 Buffer contents hold indefinitely while full and not granted, across any number of polarity changes.

Reset
REQ-027 On reset: full[1:0] = 0, buf[*] = 0, proto_err = 0.
REQ-028 Outputs during and after reset: ri = 1, req_ring = 0, req_pe = 0, dout = 0.
REQ-029 Reset asserted mid-operation discards buffered packets without issuing a request.
REQ-030 Reset has priority over simultaneous write or grant.

Structure
REQ-031 A shared package holds DATA_WIDTH, VC_BIT = 63, DIR_BIT = 62, HOP_MSB = 55, and HOP_LSB = 48, for reuse by the NIC and the other router ports.
REQ-032 One sub-module, vc_slot (single-entry register with full bit and load/clear), is instantiated twice; all other logic is inline.

Verification
REQ-033 Basic transfer: after reset, polarity = 1, si = 1, di = 64'h0003_0000_0000_00AA (VC 0, hop 3) -> ri was 1, next cycle (polarity = 0) req_ring = 1 and dout = 64'h0002_0000_0000_00AA.
REQ-034 Local delivery: hop 0 packet on VC 1 accepted at polarity = 0 -> next cycle req_pe = 1, req_ring = 0, dout equals di; after gnt, full clears and ri = 1 at polarity = 0.
REQ-035 Backpressure: buf[0] full and not granted, polarity = 1 -> ri = 0; si pulse is ignored, the buffer is unchanged and proto_err = 0.
REQ-036 Wrong VC: polarity = 1, si = 1, di[63] = 1 -> packet dropped, proto_err = 1 and stays 1 until reset.
REQ-037 Simultaneous events: buf[1] full, polarity = 1, gnt = 1 and si = 1 with a VC 0 packet in the same cycle -> buf[1] clears and buf[0] loads in that same edge.
REQ-038 Reset mid-flight: both buffers full, reset = 1 for one cycle -> req_ring = req_pe = 0, dout = 0 and ri = 1 on the following cycle.

Source files
------------

// File: rtl/vc_input_port_pkg.sv
// Shared packet-field constants for the NIC and the router ports.
package vc_input_port_pkg;
  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned VC_BIT     = 63;
  localparam int unsigned DIR_BIT    = 62;
  localparam int unsigned HOP_MSB    = 55;
  localparam int unsigned HOP_LSB    = 48;
  localparam int unsigned HOP_W      = HOP_MSB - HOP_LSB + 1;
  localparam int unsigned NUM_VC     = 2;
endpackage

// File: rtl/vc_input_port_if.sv
// Upstream send/ready and downstream request/grant bundle of one router input port.
interface vc_input_port_if
  import vc_input_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = vc_input_port_pkg::DATA_WIDTH
);
  logic                  si;
  logic                  ri;
  logic [DATA_WIDTH-1:0] di;
  logic                  req_ring;
  logic                  req_pe;
  logic                  gnt;
  logic [DATA_WIDTH-1:0] dout;

  modport master (output si, di, gnt, input ri, req_ring, req_pe, dout);
  modport slave  (input si, di, gnt, output ri, req_ring, req_pe, dout);
endinterface

// File: rtl/vc_input_port_vc_slot.sv
// Single-entry packet register with full bit; load and clear never target the same slot together.
module vc_slot
  import vc_input_port_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/vc_input_port.sv
// Two-VC router input port: external VC is ~polarity, the internal VC presents with hop decremented.
module vc_input_port
  import vc_input_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = vc_input_port_pkg::DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             polarity,
  vc_input_port_if.slave   bus,
  output logic             proto_err
);
  logic [DATA_WIDTH-1:0] slot_q [NUM_VC];
  logic [NUM_VC-1:0]     slot_full;
  logic [NUM_VC-1:0]     slot_load;
  logic [NUM_VC-1:0]     slot_clear;
  logic                  ext_vc;
  logic                  ri_w;
  logic                  accept;
  logic                  wrong_vc;
  logic [DATA_WIDTH-1:0] cur;
  logic [HOP_W-1:0]      hop;
  logic                  cur_full;
  logic [DATA_WIDTH-1:0] fwd;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_slot
    vc_slot #(.WIDTH(DATA_WIDTH)) u_slot (
      .clk   (clk),
      .reset (reset),
      .load  (slot_load[v]),
      .clear (slot_clear[v]),
      .d     (bus.di),
      .q     (slot_q[v]),
      .full  (slot_full[v])
    );
  end

  assign ext_vc   = ~polarity;
  assign ri_w     = ~slot_full[ext_vc];
  assign accept   = bus.si & ri_w;
  assign wrong_vc = accept & (bus.di[VC_BIT] == polarity);
  assign cur      = slot_q[polarity];
  assign cur_full = slot_full[polarity];
  assign hop      = cur[HOP_MSB:HOP_LSB];

  // Write steers to the external slot, grant drains the internal slot; they never collide.
  always_comb begin
    slot_load  = '0;
    slot_clear = '0;
    if (accept && (bus.di[VC_BIT] == ext_vc)) slot_load[ext_vc] = 1'b1;
    if (bus.gnt && cur_full)                  slot_clear[polarity] = 1'b1;
  end

  // Hop 0 is local delivery and is never decremented, so no wrap is possible.
  always_comb begin
    fwd = cur;
    if (hop != '0) fwd[HOP_MSB:HOP_LSB] = hop - HOP_W'(1);
  end

  assign bus.ri       = ri_w;
  assign bus.req_ring = cur_full & (hop != '0);
  assign bus.req_pe   = cur_full & (hop == '0);
  assign bus.dout     = cur_full ? fwd : '0;

  always_ff @(posedge clk) begin
    if (reset)         proto_err <= 1'b0;
    else if (wrong_vc) proto_err <= 1'b1;
  end
endmodule

// File: tb/tb_vc_input_port.sv
// Directed and randomized bench for vc_input_port against a packet-level reference model.
module tb_vc_input_port;
  localparam int unsigned W = 64;

  logic clk = 1'b0;
  logic reset;
  logic polarity;
  logic proto_err;

  vc_input_port_if #(.DATA_WIDTH(W)) bus ();

  vc_input_port #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .polarity  (polarity),
    .bus       (bus),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: two held packets, their occupancy, and the sticky error.
  logic [W-1:0] m_pkt [2];
  bit           m_has [2];
  bit           m_err;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_dout(input bit p);
    logic [W-1:0] b;
    logic [7:0]   h;
    if (!m_has[p]) return '0;
    b = m_pkt[p];
    h = b[55:48];
    if (h != 8'd0) b[55:48] = h - 8'd1;
    return b;
  endfunction

  task automatic drive(input bit p, input bit s, input bit g, input bit r, input logic [W-1:0] d);
    polarity = p;
    bus.si   = s;
    bus.gnt  = g;
    reset    = r;
    bus.di   = d;
    #1;
  endtask

  task automatic check_model(input string tag);
    bit p;
    int h;
    p = polarity;
    h = int'(m_pkt[p][55:48]);
    chk({tag, ".ri"},        W'(bus.ri),       W'(!m_has[!p]));
    chk({tag, ".req_ring"},  W'(bus.req_ring), W'(m_has[p] && h != 0));
    chk({tag, ".req_pe"},    W'(bus.req_pe),   W'(m_has[p] && h == 0));
    chk({tag, ".dout"},      bus.dout,         model_dout(p));
    chk({tag, ".proto_err"}, W'(proto_err),    W'(m_err));
  endtask

  // Apply the packet-level rules for the current inputs, then let the clock edge happen.
  task automatic tick();
    bit p, e;
    p = polarity;
    e = !p;
    if (reset) begin
      m_has[0] = 0; m_has[1] = 0; m_pkt[0] = '0; m_pkt[1] = '0; m_err = 0;
    end else begin
      if (bus.si && !m_has[e]) begin
        if (bus.di[63] == e) begin m_pkt[e] = bus.di; m_has[e] = 1; end
        else m_err = 1;
      end
      if (bus.gnt && m_has[p]) m_has[p] = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [W-1:0] d;

  initial begin
    m_has[0] = 0; m_has[1] = 0; m_pkt[0] = '0; m_pkt[1] = '0; m_err = 0;
    drive(0, 0, 0, 1, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    drive(0, 0, 0, 1, '0);
    check_model("reset");
    chk("reset.ri_const", W'(bus.ri), W'(1));
    tick();

    // Basic transfer, VC 0 hop 3
    drive(1, 1, 0, 0, 64'h0003_0000_0000_00AA);
    check_model("basic_in");
    tick();
    drive(0, 0, 0, 0, '0);
    check_model("basic_out");
    chk("basic.dout_const", bus.dout, 64'h0002_0000_0000_00AA);
    chk("basic.req_ring_const", W'(bus.req_ring), W'(1));
    drive(0, 0, 1, 0, '0);
    tick();

    // Local delivery, VC 1 hop 0
    d = 64'h8000_0000_1234_0055;
    drive(0, 1, 0, 0, d);
    check_model("local_in");
    tick();
    drive(1, 0, 0, 0, '0);
    check_model("local_out");
    chk("local.dout_unchanged", bus.dout, d);
    drive(1, 0, 1, 0, '0);
    tick();
    drive(0, 0, 0, 0, '0);
    check_model("local_drained");
    chk("local.ri_const", W'(bus.ri), W'(1));

    // Backpressure on buf[0]
    drive(1, 1, 0, 0, 64'h0005_0000_0000_0011);
    tick();
    drive(1, 1, 0, 0, 64'h0007_0000_0000_0022);
    check_model("bp_block");
    chk("bp.ri_const", W'(bus.ri), W'(0));
    tick();
    drive(0, 0, 0, 0, '0);
    check_model("bp_held");
    chk("bp.dout_const", bus.dout, 64'h0004_0000_0000_0011);
    drive(0, 0, 1, 0, '0);
    tick();

    // Simultaneous grant of buf[1] and load of buf[0]
    drive(0, 1, 0, 0, 64'h8002_0000_0000_0033);
    tick();
    drive(1, 1, 1, 0, 64'h0001_0000_0000_0044);
    check_model("simul_pre");
    tick();
    drive(1, 0, 0, 0, '0);
    check_model("simul_b1_cleared");
    drive(0, 0, 0, 0, '0);
    check_model("simul_b0_loaded");
    chk("simul.dout_const", bus.dout, 64'h0000_0000_0000_0044);

    // Reset mid-flight with both buffers full
    drive(0, 1, 0, 0, 64'h8009_0000_0000_0066);
    tick();
    drive(0, 1, 1, 1, 64'h0001_0000_0000_0077);
    tick();
    drive(0, 0, 0, 0, '0);
    check_model("rst_mid_p0");
    drive(1, 0, 0, 0, '0);
    check_model("rst_mid_p1");
    chk("rst_mid.dout_const", bus.dout, W'(0));

    // Wrong VC is dropped and sticky
    drive(1, 1, 0, 0, 64'h8003_0000_0000_0088);
    tick();
    drive(1, 0, 0, 0, '0);
    check_model("wrongvc_set");
    chk("wrongvc.err_const", W'(proto_err), W'(1));
    repeat (3) begin
      drive(!polarity, 0, 1, 0, '0);
      tick();
    end
    drive(0, 0, 0, 0, '0);
    check_model("wrongvc_sticky");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      d = {$urandom, $urandom};
      d[55:48] = 8'($urandom_range(0, 3));
      drive(1'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0), d);
      check_model("rand");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
